// File: rtl/aha_reset_sequencer.sv
// rtl/aha_reset_sequencer.sv - staggered boot reset release and per-domain warm-reset sequencer
// All outputs are registered because DOMAIN_RESETn_REQ and DOMAIN_CLKEN cross into other clock domains.
module aha_reset_sequencer #(
  parameter int NUM_DOMAINS    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int GATE_CYCLES    = 4,
  parameter int CNT_W          = 8
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [NUM_DOMAINS-1:0] SW_RST_REQ,
  output logic [NUM_DOMAINS-1:0] SW_RST_ACK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESETn_REQ,
  output logic [NUM_DOMAINS-1:0] DOMAIN_CLKEN,
  output logic                   SEQ_DONE,
  output logic                   BUSY
);

  localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int BIDX_W = $clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAG_LD  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GATE_LD  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [BIDX_W-1:0] BOOT_END = BIDX_W'(NUM_DOMAINS);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_GATE,
    ST_HOLD,
    ST_SETTLE,
    ST_FINISH,
    ST_ACK
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [BIDX_W-1:0]      boot_idx, boot_idx_nxt;
  logic [NUM_DOMAINS-1:0] rstn_nxt, clken_nxt, ack_nxt;
  logic                   done_nxt;

  logic [NUM_DOMAINS-1:0] pend, grant_oh, idx_oh, boot_oh;
  logic [IDX_W-1:0]       grant_idx;
  logic                   req_cur;

  assign pend     = SW_RST_REQ & ~SW_RST_ACK;
  // Isolate the lowest set bit: lowest index has fixed priority.
  assign grant_oh = pend & ~(pend - 1'b1);
  assign req_cur  = |(SW_RST_REQ & idx_oh);

  always_comb begin
    grant_idx = '0;
    idx_oh    = '0;
    boot_oh   = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (grant_oh[k]) grant_idx = IDX_W'(k);
      if (IDX_W'(k) == idx) idx_oh[k] = 1'b1;
      if (BIDX_W'(k) == boot_idx) boot_oh[k] = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    boot_idx_nxt = boot_idx;
    rstn_nxt     = DOMAIN_RESETn_REQ;
    clken_nxt    = DOMAIN_CLKEN;
    ack_nxt      = SW_RST_ACK;
    done_nxt     = SEQ_DONE;
    if (cnt != '0) cnt_nxt = cnt - 1'b1;

    case (state)
      ST_BOOT: begin
        if (cnt == '0) begin
          if (boot_idx == BOOT_END) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            rstn_nxt     = DOMAIN_RESETn_REQ | boot_oh;
            boot_idx_nxt = boot_idx + 1'b1;
            cnt_nxt      = STAG_LD;
          end
        end
      end
      ST_IDLE: begin
        if (pend != '0) begin
          idx_nxt   = grant_idx;
          clken_nxt = DOMAIN_CLKEN & ~grant_oh;
          cnt_nxt   = GATE_LD;
          state_nxt = ST_GATE;
        end
      end
      ST_GATE: begin
        if (cnt == '0) begin
          rstn_nxt  = DOMAIN_RESETn_REQ & ~idx_oh;
          cnt_nxt   = HOLD_LD;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          rstn_nxt  = DOMAIN_RESETn_REQ | idx_oh;
          cnt_nxt   = STAG_LD;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          clken_nxt = DOMAIN_CLKEN | idx_oh;
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // A request dropped mid-sequence still gets the full pulse, but no ACK.
        if (req_cur) begin
          ack_nxt   = SW_RST_ACK | idx_oh;
          state_nxt = ST_ACK;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!req_cur) begin
          ack_nxt   = SW_RST_ACK & ~idx_oh;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state             <= ST_BOOT;
      cnt               <= HOLD_LD;
      idx               <= '0;
      boot_idx          <= '0;
      DOMAIN_RESETn_REQ <= '0;
      DOMAIN_CLKEN      <= '1;
      SW_RST_ACK        <= '0;
      SEQ_DONE          <= 1'b0;
      BUSY              <= 1'b1;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      idx               <= idx_nxt;
      boot_idx          <= boot_idx_nxt;
      DOMAIN_RESETn_REQ <= rstn_nxt;
      DOMAIN_CLKEN      <= clken_nxt;
      SW_RST_ACK        <= ack_nxt;
      SEQ_DONE          <= done_nxt;
      BUSY              <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_aha_reset_sequencer.sv
// tb/tb_aha_reset_sequencer.sv - bench for aha_reset_sequencer: timing tables, corner sequences, random vs model
module tb_aha_reset_sequencer;

  localparam int N = 2;
  localparam int H = 16;
  localparam int S = 8;
  localparam int G = 4;
  localparam int W = 8;
  localparam int T_BOOT = H + N * S;
  localparam int T_DEC  = G + H + S + 1;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic [N-1:0] rstn_req;
  logic [N-1:0] clken;
  logic         seq_done;
  logic         busy;

  aha_reset_sequencer #(
    .NUM_DOMAINS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .GATE_CYCLES(G), .CNT_W(W)
  ) dut (
    .CLK(clk),
    .RESETn(rst_n),
    .SW_RST_REQ(req),
    .SW_RST_ACK(ack),
    .DOMAIN_RESETn_REQ(rstn_req),
    .DOMAIN_CLKEN(clken),
    .SEQ_DONE(seq_done),
    .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   off;
    logic rstn_g;
    logic clken_g;
    logic ack_g;
    logic busy;
  } wvec_t;

  typedef struct {
    int         edge_n;
    logic [1:0] rstn;
    logic       done;
    logic       busy;
  } bvec_t;

  wvec_t wv[8];
  bvec_t bv[7];

  int checks = 0;
  int errors = 0;

  // Reference model: edge count since reset release, phase, grant time and granted domain.
  int e, t0, gi, mode;  // mode: 0 boot, 1 idle, 2 sequence, 3 acknowledging

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, e, act, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; t0 = 0; gi = 0; mode = 0;
  endtask

  task automatic model_edge();
    e++;
    case (mode)
      0: if (e == T_BOOT) mode = 1;
      1: if (req != '0) begin
           gi = 0;
           while (!req[gi]) gi++;
           t0   = e;
           mode = 2;
         end
      2: if (e == t0 + T_DEC) mode = req[gi] ? 3 : 1;
      default: if (!req[gi]) mode = 1;
    endcase
  endtask

  task automatic check_model();
    logic [N-1:0] xr, xc, xa;
    for (int k = 0; k < N; k++) begin
      xr[k] = (e >= H + k * S);
      xc[k] = 1'b1;
      xa[k] = 1'b0;
    end
    if (mode == 2) begin
      if (e >= t0 + G && e < t0 + G + H) xr[gi] = 1'b0;
      if (e < t0 + G + H + S) xc[gi] = 1'b0;
    end
    if (mode == 3) xa[gi] = 1'b1;
    chk("model_rstn", rstn_req, xr);
    chk("model_clken", clken, xc);
    chk("model_ack", ack, xa);
    chk("model_done", seq_done, (e >= T_BOOT));
    chk("model_busy", busy, (mode != 1));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_model();
  endtask

  task automatic run_until(input int target);
    for (int g = 0; g < 2000 && e < target; g++) step();
    chk("run_until_reached", (e >= target), 1'b1);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_rstn", rstn_req, 2'b00);
    chk("rst_async_clken", clken, 2'b11);
    chk("rst_async_ack", ack, 2'b00);
    chk("rst_async_done", seq_done, 1'b0);
    chk("rst_async_busy", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_boot_table();
    for (int i = 0; i < 7; i++) begin
      run_until(bv[i].edge_n);
      chk("boot_rstn", rstn_req, bv[i].rstn);
      chk("boot_clken", clken, 2'b11);
      chk("boot_done", seq_done, bv[i].done);
      chk("boot_busy", busy, bv[i].busy);
    end
  endtask

  task automatic run_warm_table(input int start, input int d);
    logic [1:0] xr, xc, xa;
    for (int i = 0; i < 8; i++) begin
      run_until(start + wv[i].off);
      xr = 2'b11; xr[d] = wv[i].rstn_g;
      xc = 2'b11; xc[d] = wv[i].clken_g;
      xa = 2'b00; xa[d] = wv[i].ack_g;
      chk("warm_rstn", rstn_req, xr);
      chk("warm_clken", clken, xc);
      chk("warm_ack", ack, xa);
      chk("warm_busy", busy, wv[i].busy);
    end
  endtask

  initial begin
    int ts;
    wv[0] = '{0,  1'b1, 1'b0, 1'b0, 1'b1};
    wv[1] = '{3,  1'b1, 1'b0, 1'b0, 1'b1};
    wv[2] = '{4,  1'b0, 1'b0, 1'b0, 1'b1};
    wv[3] = '{19, 1'b0, 1'b0, 1'b0, 1'b1};
    wv[4] = '{20, 1'b1, 1'b0, 1'b0, 1'b1};
    wv[5] = '{27, 1'b1, 1'b0, 1'b0, 1'b1};
    wv[6] = '{28, 1'b1, 1'b1, 1'b0, 1'b1};
    wv[7] = '{29, 1'b1, 1'b1, 1'b1, 1'b1};
    bv[0] = '{1,  2'b00, 1'b0, 1'b1};
    bv[1] = '{15, 2'b00, 1'b0, 1'b1};
    bv[2] = '{16, 2'b01, 1'b0, 1'b1};
    bv[3] = '{23, 2'b01, 1'b0, 1'b1};
    bv[4] = '{24, 2'b11, 1'b0, 1'b1};
    bv[5] = '{31, 2'b11, 1'b0, 1'b1};
    bv[6] = '{32, 2'b11, 1'b1, 1'b0};

    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (3) step();
    chk("reset_rstn", rstn_req, 2'b00);
    chk("reset_clken", clken, 2'b11);
    chk("reset_ack", ack, 2'b00);
    chk("reset_done", seq_done, 1'b0);
    chk("reset_busy", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_boot_table();

    // Single warm reset of domain 0.
    run_until(40);
    req = 2'b01; ts = e + 1;
    run_warm_table(ts, 0);
    req = 2'b00;
    step();
    chk("single_ack_drop", ack, 2'b00);
    chk("single_idle", busy, 1'b0);

    // Contention: domain 0 first, domain 1 the edge after ACK[0] falls.
    step();
    req = 2'b11; ts = e + 1;
    run_warm_table(ts, 0);
    req = 2'b10;
    step();
    chk("cont_ack0_drop", ack, 2'b00);
    chk("cont_gap_clken", clken, 2'b11);
    run_warm_table(ts + 31, 1);
    req = 2'b00;
    step();
    chk("cont_ack1_drop", ack, 2'b00);

    // Request held from edge 5 of boot is serviced at edge 33.
    apply_reset();
    run_until(4);
    req = 2'b10;
    run_until(32);
    chk("boot_req_clken32", clken, 2'b11);
    chk("boot_req_busy32", busy, 1'b0);
    step();
    chk("boot_req_clken33", clken, 2'b01);
    chk("boot_req_busy33", busy, 1'b1);
    run_warm_table(33, 1);
    req = 2'b00;
    step();

    // Early drop at t0+10: full pulse, no ACK, idle at t0+29.
    step();
    req = 2'b01; ts = e + 1;
    run_until(ts + 4);
    chk("drop_rstn_low4", rstn_req, 2'b10);
    run_until(ts + 9);
    req = 2'b00;
    run_until(ts + 19);
    chk("drop_rstn_low19", rstn_req, 2'b10);
    step();
    chk("drop_rstn_high20", rstn_req, 2'b11);
    run_until(ts + 28);
    chk("drop_clken28", clken, 2'b11);
    step();
    chk("drop_no_ack", ack, 2'b00);
    chk("drop_idle29", busy, 1'b0);

    // Reset in the middle of a warm reset, then boot timing repeats.
    step();
    req = 2'b01; ts = e + 1;
    run_until(ts + 11);
    req = 2'b00;
    apply_reset();
    run_boot_table();

    // Random request traffic with rare async resets, checked every edge by the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      if ($urandom_range(0, 11) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 1499) == 0) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
